// File: rtl/argon_pkg.sv
// Shared definitions for the argon operand-fetch slice: data width default,
// register index width and the operand-stage FSM encoding.
package argon_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 1 << REG_ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUED = 2'd1,
    STALL  = 2'd2
  } of_state_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Bundle of decode, register-file, writeback and execute signals around the
// operand stage, plus debug visibility of the FSM state and scoreboard.
interface operand_fetch_if #(
    parameter int XLEN = argon_pkg::XLEN_DEFAULT
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and a held o_ex_valid keeps all ex
    // outputs stable until i_ex_ready. An i_flush cycle cancels the transfer.
    logic                                 i_dec_valid;
    logic                                 o_dec_ready;
    logic [argon_pkg::REG_ADDR_W-1:0]     i_dec_rs1;
    logic [argon_pkg::REG_ADDR_W-1:0]     i_dec_rs2;
    logic [argon_pkg::REG_ADDR_W-1:0]     i_dec_rd;
    logic                                 i_dec_wr;
    logic [argon_pkg::REG_ADDR_W-1:0]     o_rf_selA;
    logic [argon_pkg::REG_ADDR_W-1:0]     o_rf_selB;
    logic [XLEN-1:0]                      i_rf_portA;
    logic [XLEN-1:0]                      i_rf_portB;
    logic                                 i_wb_valid;
    logic [argon_pkg::REG_ADDR_W-1:0]     i_wb_rd;
    logic [XLEN-1:0]                      i_wb_data;
    logic                                 o_ex_valid;
    logic                                 i_ex_ready;
    logic [XLEN-1:0]                      o_ex_opA;
    logic [XLEN-1:0]                      o_ex_opB;
    logic [argon_pkg::REG_ADDR_W-1:0]     o_ex_rd;
    logic                                 o_ex_wr;
    logic                                 i_flush;
    argon_pkg::of_state_t                 dbg_state;
    logic [argon_pkg::NUM_REGS-1:0]       dbg_pending;

    modport slave (
        input  i_dec_valid, i_dec_rs1, i_dec_rs2, i_dec_rd, i_dec_wr,
        input  i_rf_portA, i_rf_portB, i_wb_valid, i_wb_rd, i_wb_data,
        input  i_ex_ready, i_flush,
        output o_dec_ready, o_rf_selA, o_rf_selB,
        output o_ex_valid, o_ex_opA, o_ex_opB, o_ex_rd, o_ex_wr,
        output dbg_state, dbg_pending
    );

    modport master (
        output i_dec_valid, i_dec_rs1, i_dec_rs2, i_dec_rd, i_dec_wr,
        output i_rf_portA, i_rf_portB, i_wb_valid, i_wb_rd, i_wb_data,
        output i_ex_ready, i_flush,
        input  o_dec_ready, o_rf_selA, o_rf_selB,
        input  o_ex_valid, o_ex_opA, o_ex_opB, o_ex_rd, o_ex_wr,
        input  dbg_state, dbg_pending
    );

endinterface

// File: rtl/operand_scoreboard.sv
// Pending-write scoreboard for x1..x31; queries already see a same-cycle
// writeback clear so a hazard resolves in the cycle its data arrives.
module operand_scoreboard
    import argon_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    set_en,
    input  logic [REG_ADDR_W-1:0]   set_idx,
    input  logic                    clr_en,
    input  logic [REG_ADDR_W-1:0]   clr_idx,
    input  logic                    flush_en,
    input  logic [REG_ADDR_W-1:0]   flush_idx,
    input  logic [REG_ADDR_W-1:0]   q1_idx,
    input  logic [REG_ADDR_W-1:0]   q2_idx,
    input  logic [REG_ADDR_W-1:0]   q3_idx,
    output logic                    q1_busy,
    output logic                    q2_busy,
    output logic                    q3_busy,
    output logic [NUM_REGS-1:0]     pending
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    assign q1_busy = pend_q[q1_idx] && !(clr_en && (clr_idx == q1_idx));
    assign q2_busy = pend_q[q2_idx] && !(clr_en && (clr_idx == q2_idx));
    assign q3_busy = pend_q[q3_idx] && !(clr_en && (clr_idx == q3_idx));
    assign pending = pend_q;

    // A new claim on an index outranks a writeback retiring the older claim.
    always_comb begin
        pend_d = pend_q;
        if (clr_en)   pend_d[clr_idx]   = 1'b0;
        if (flush_en) pend_d[flush_idx] = 1'b0;
        if (set_en)   pend_d[set_idx]   = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) pend_q <= '0;
        else         pend_q <= pend_d;
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand stage: reads the register file, resolves hazards through the
// scoreboard and a writeback bypass, and presents operands to execute.
module operand_fetch
    import argon_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_reset,
    operand_fetch_if.slave  bus
);

    of_state_t              state;
    logic                   ex_valid_q;
    logic [REG_ADDR_W-1:0]  ex_rd_q;
    logic                   ex_wr_q;
    logic                   a_zero_q, b_zero_q;
    logic                   byp_a_v_q, byp_b_v_q;
    logic [XLEN-1:0]        byp_a_q, byp_b_q;
    logic [XLEN-1:0]        hold_a_q, hold_b_q;
    logic [XLEN-1:0]        issue_a, issue_b;
    logic                   busy1, busy2, busy3;
    logic                   hazard, accept, flush_held, byp_a_hit, byp_b_hit;

    operand_scoreboard u_scoreboard (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .set_en    (accept && bus.i_dec_wr && (bus.i_dec_rd != '0)),
        .set_idx   (bus.i_dec_rd),
        .clr_en    (bus.i_wb_valid),
        .clr_idx   (bus.i_wb_rd),
        .flush_en  (flush_held),
        .flush_idx (ex_rd_q),
        .q1_idx    (bus.i_dec_rs1),
        .q2_idx    (bus.i_dec_rs2),
        .q3_idx    (bus.i_dec_rd),
        .q1_busy   (busy1),
        .q2_busy   (busy2),
        .q3_busy   (busy3),
        .pending   (bus.dbg_pending)
    );

    assign bus.o_rf_selA = bus.i_dec_rs1;
    assign bus.o_rf_selB = bus.i_dec_rs2;

    assign hazard      = busy1 || busy2 || (busy3 && bus.i_dec_wr);
    assign bus.o_dec_ready = !hazard && !bus.i_flush && ((state == IDLE) || bus.i_ex_ready);
    assign accept      = bus.i_dec_valid && bus.o_dec_ready;
    assign flush_held  = bus.i_flush && (state != IDLE) && ex_wr_q;
    assign byp_a_hit   = bus.i_wb_valid && (bus.i_wb_rd == bus.i_dec_rs1) && (bus.i_dec_rs1 != '0);
    assign byp_b_hit   = bus.i_wb_valid && (bus.i_wb_rd == bus.i_dec_rs2) && (bus.i_dec_rs2 != '0);

    // The register file was read before the accept-cycle writeback landed,
    // so the latched bypass value takes precedence over the read port.
    assign issue_a = a_zero_q ? '0 : (byp_a_v_q ? byp_a_q : bus.i_rf_portA);
    assign issue_b = b_zero_q ? '0 : (byp_b_v_q ? byp_b_q : bus.i_rf_portB);

    assign bus.o_ex_valid = ex_valid_q;
    assign bus.o_ex_opA   = (state == ISSUED) ? issue_a : hold_a_q;
    assign bus.o_ex_opB   = (state == ISSUED) ? issue_b : hold_b_q;
    assign bus.o_ex_rd    = ex_rd_q;
    assign bus.o_ex_wr    = ex_wr_q;
    assign bus.dbg_state  = state;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            ex_wr_q    <= 1'b0;
            a_zero_q   <= 1'b0;
            b_zero_q   <= 1'b0;
            byp_a_v_q  <= 1'b0;
            byp_b_v_q  <= 1'b0;
            byp_a_q    <= '0;
            byp_b_q    <= '0;
            hold_a_q   <= '0;
            hold_b_q   <= '0;
        end else begin
            if (accept) begin
                ex_rd_q   <= bus.i_dec_rd;
                ex_wr_q   <= bus.i_dec_wr;
                a_zero_q  <= (bus.i_dec_rs1 == '0);
                b_zero_q  <= (bus.i_dec_rs2 == '0);
                byp_a_v_q <= byp_a_hit;
                byp_b_v_q <= byp_b_hit;
                byp_a_q   <= byp_a_hit ? bus.i_wb_data : '0;
                byp_b_q   <= byp_b_hit ? bus.i_wb_data : '0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= ISSUED;
                        ex_valid_q <= 1'b1;
                    end
                end
                ISSUED, STALL: begin
                    if (bus.i_flush) begin
                        state      <= IDLE;
                        ex_valid_q <= 1'b0;
                    end else if (bus.i_ex_ready) begin
                        state      <= accept ? ISSUED : IDLE;
                        ex_valid_q <= accept;
                    end else if (state == ISSUED) begin
                        // Read ports move on with the next select; freeze operands.
                        hold_a_q <= issue_a;
                        hold_b_q <= issue_b;
                        state    <= STALL;
                    end
                end
                default: begin
                    state      <= IDLE;
                    ex_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: one task per scenario, each checking
// outputs against hand-computed values around a small register-file model.
module tb_operand_fetch;
  import argon_pkg::*;

  localparam int XLEN = 32;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  int vecs = 0;
  int errs = 0;

  operand_fetch_if #(.XLEN(XLEN)) bus ();

  operand_fetch #(.XLEN(XLEN)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  // Register file model: registered read of the pre-write contents.
  // x0 deliberately reads garbage so the stage must force it to zero.
  function automatic logic [XLEN-1:0] seed(input int i);
    case (i)
      0:       return 32'hDEAD_BEEF;
      3:       return 32'h0000_0011;
      default: return 32'h0000_0100 + i;
    endcase
  endfunction

  logic [XLEN-1:0] rf [NUM_REGS];

  always @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= seed(i);
    end else begin
      bus.i_rf_portA <= rf[bus.o_rf_selA];
      bus.i_rf_portB <= rf[bus.o_rf_selB];
      if (bus.i_wb_valid) rf[bus.i_wb_rd] <= bus.i_wb_data;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic wr);
    bus.i_dec_valid = v;
    bus.i_dec_rs1   = rs1;
    bus.i_dec_rs2   = rs2;
    bus.i_dec_rd    = rd;
    bus.i_dec_wr    = wr;
  endtask

  task automatic test_reset();
    drive_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    bus.i_wb_valid = 1'b0; bus.i_wb_rd = 5'd0; bus.i_wb_data = '0;
    bus.i_ex_ready = 1'b1; bus.i_flush = 1'b0;
    bus.i_rf_portA = '0; bus.i_rf_portB = '0;
    i_reset = 1'b1;
    tick(); tick();
    #2 i_reset = 1'b0;
    tick();
    vecs++; if (bus.o_ex_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %0b want 0", bus.o_ex_valid); end
    vecs++; if (bus.o_ex_opA !== 32'h0 || bus.o_ex_opB !== 32'h0) begin errs++; $display("FAIL reset_ops got %h/%h want 0/0", bus.o_ex_opA, bus.o_ex_opB); end
    vecs++; if (bus.o_ex_rd !== 5'd0 || bus.o_ex_wr !== 1'b0) begin errs++; $display("FAIL reset_rd got %0d/%0b want 0/0", bus.o_ex_rd, bus.o_ex_wr); end
    vecs++; if (bus.dbg_pending !== 32'h0) begin errs++; $display("FAIL reset_pending got %h want 0", bus.dbg_pending); end
    vecs++; if (bus.dbg_state !== IDLE) begin errs++; $display("FAIL reset_state got %0d want IDLE", bus.dbg_state); end
    drive_dec(1'b0, 5'd17, 5'd22, 5'd0, 1'b0);
    #1;
    vecs++; if (bus.o_rf_selA !== 5'd17 || bus.o_rf_selB !== 5'd22) begin errs++; $display("FAIL rf_sel got %0d/%0d want 17/22", bus.o_rf_selA, bus.o_rf_selB); end
    vecs++; if (bus.o_dec_ready !== 1'b1) begin errs++; $display("FAIL reset_dec_ready got %0b want 1", bus.o_dec_ready); end
  endtask

  task automatic test_basic_issue();
    drive_dec(1'b1, 5'd3, 5'd0, 5'd5, 1'b1);
    tick();
    drive_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    vecs++; if (bus.o_ex_valid !== 1'b1) begin errs++; $display("FAIL basic_valid got %0b want 1", bus.o_ex_valid); end
    vecs++; if (bus.o_ex_opA !== 32'h11) begin errs++; $display("FAIL basic_opA got %h want 00000011", bus.o_ex_opA); end
    vecs++; if (bus.o_ex_opB !== 32'h0) begin errs++; $display("FAIL basic_opB_x0 got %h want 0", bus.o_ex_opB); end
    vecs++; if (bus.o_ex_rd !== 5'd5 || bus.o_ex_wr !== 1'b1) begin errs++; $display("FAIL basic_rd got %0d/%0b want 5/1", bus.o_ex_rd, bus.o_ex_wr); end
    vecs++; if (bus.dbg_pending !== 32'h0000_0020) begin errs++; $display("FAIL basic_pending got %h want 00000020", bus.dbg_pending); end
    tick();
    vecs++; if (bus.o_ex_valid !== 1'b0 || bus.dbg_state !== IDLE) begin errs++; $display("FAIL basic_retire got %0b/%0d want 0/IDLE", bus.o_ex_valid, bus.dbg_state); end
  endtask

  task automatic test_bypass();
    drive_dec(1'b1, 5'd5, 5'd0, 5'd6, 1'b0);
    #1;
    vecs++; if (bus.o_dec_ready !== 1'b0) begin errs++; $display("FAIL raw_hazard_ready got %0b want 0", bus.o_dec_ready); end
    bus.i_wb_valid = 1'b1; bus.i_wb_rd = 5'd5; bus.i_wb_data = 32'hAB;
    #1;
    vecs++; if (bus.o_dec_ready !== 1'b1) begin errs++; $display("FAIL wb_release_ready got %0b want 1", bus.o_dec_ready); end
    tick();
    drive_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    bus.i_wb_valid = 1'b0;
    vecs++; if (bus.o_ex_valid !== 1'b1 || bus.o_ex_opA !== 32'hAB) begin errs++; $display("FAIL bypass_opA got %0b/%h want 1/000000ab", bus.o_ex_valid, bus.o_ex_opA); end
    vecs++; if (bus.o_ex_wr !== 1'b0 || bus.dbg_pending !== 32'h0) begin errs++; $display("FAIL bypass_pending got %0b/%h want 0/0", bus.o_ex_wr, bus.dbg_pending); end
    tick();
  endtask

  task automatic test_stall_back_to_back();
    bus.i_ex_ready = 1'b0;
    drive_dec(1'b1, 5'd1, 5'd2, 5'd8, 1'b1);
    tick();
    drive_dec(1'b1, 5'd2, 5'd1, 5'd10, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      vecs++; if (bus.dbg_state !== ((c == 0) ? ISSUED : STALL)) begin errs++; $display("FAIL stall_state c%0d got %0d want %0d", c, bus.dbg_state, (c == 0) ? 1 : 2); end
      vecs++; if (bus.o_ex_valid !== 1'b1 || bus.o_ex_opA !== 32'h101 || bus.o_ex_opB !== 32'h102) begin errs++; $display("FAIL stall_hold c%0d got %0b/%h/%h want 1/00000101/00000102", c, bus.o_ex_valid, bus.o_ex_opA, bus.o_ex_opB); end
      vecs++; if (bus.o_dec_ready !== 1'b0 || bus.o_ex_rd !== 5'd8) begin errs++; $display("FAIL stall_ready c%0d got %0b/%0d want 0/8", c, bus.o_dec_ready, bus.o_ex_rd); end
      if (c < 2) tick();
    end
    bus.i_ex_ready = 1'b1;
    #1;
    vecs++; if (bus.o_dec_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready got %0b want 1", bus.o_dec_ready); end
    tick();
    drive_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    vecs++; if (bus.dbg_state !== ISSUED || bus.o_ex_opA !== 32'h102 || bus.o_ex_opB !== 32'h101 || bus.o_ex_rd !== 5'd10) begin errs++; $display("FAIL b2b_issue got %0d/%h/%h/%0d want 1/00000102/00000101/10", bus.dbg_state, bus.o_ex_opA, bus.o_ex_opB, bus.o_ex_rd); end
    vecs++; if (bus.dbg_pending !== 32'h0000_0500) begin errs++; $display("FAIL b2b_pending got %h want 00000500", bus.dbg_pending); end
    tick();
    drive_dec(1'b0, 5'd0, 5'd0, 5'd8, 1'b1);
    #1;
    vecs++; if (bus.o_dec_ready !== 1'b0) begin errs++; $display("FAIL waw_hazard got %0b want 0", bus.o_dec_ready); end
    bus.i_dec_wr = 1'b0;
    #1;
    vecs++; if (bus.o_dec_ready !== 1'b1) begin errs++; $display("FAIL rd_no_wr got %0b want 1", bus.o_dec_ready); end
  endtask

  task automatic test_flush();
    bus.i_ex_ready = 1'b0;
    drive_dec(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    tick();
    drive_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    vecs++; if (bus.dbg_pending !== 32'h0000_0580) begin errs++; $display("FAIL flush_pre_pending got %h want 00000580", bus.dbg_pending); end
    tick();
    vecs++; if (bus.dbg_state !== STALL) begin errs++; $display("FAIL flush_pre_state got %0d want STALL", bus.dbg_state); end
    bus.i_flush = 1'b1; bus.i_ex_ready = 1'b1;
    drive_dec(1'b1, 5'd0, 5'd0, 5'd11, 1'b1);
    #1;
    vecs++; if (bus.o_dec_ready !== 1'b0) begin errs++; $display("FAIL flush_dec_ready got %0b want 0", bus.o_dec_ready); end
    tick();
    bus.i_flush = 1'b0;
    drive_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    vecs++; if (bus.dbg_state !== IDLE || bus.o_ex_valid !== 1'b0) begin errs++; $display("FAIL flush_idle got %0d/%0b want IDLE/0", bus.dbg_state, bus.o_ex_valid); end
    vecs++; if (bus.dbg_pending !== 32'h0000_0500) begin errs++; $display("FAIL flush_pending got %h want 00000500", bus.dbg_pending); end
    bus.i_wb_valid = 1'b1; bus.i_wb_rd = 5'd8; bus.i_wb_data = 32'h88;
    tick();
    bus.i_wb_rd = 5'd10;
    tick();
    bus.i_wb_valid = 1'b0;
    vecs++; if (bus.dbg_pending !== 32'h0) begin errs++; $display("FAIL wb_clear got %h want 0", bus.dbg_pending); end
  endtask

  task automatic test_same_cycle_set_clear();
    drive_dec(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
    bus.i_wb_valid = 1'b1; bus.i_wb_rd = 5'd9; bus.i_wb_data = 32'h99;
    tick();
    bus.i_wb_valid = 1'b0;
    vecs++; if (bus.dbg_pending !== 32'h0000_0200) begin errs++; $display("FAIL set_wins got %h want 00000200", bus.dbg_pending); end
    drive_dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    tick();
    drive_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    vecs++; if (bus.dbg_pending !== 32'h0000_0200 || bus.dbg_state !== ISSUED) begin errs++; $display("FAIL x0_never_pending got %h/%0d want 00000200/1", bus.dbg_pending, bus.dbg_state); end
    vecs++; if (bus.o_ex_opA !== 32'h0 || bus.o_ex_opB !== 32'h0 || bus.o_ex_rd !== 5'd0) begin errs++; $display("FAIL x0_ops got %h/%h/%0d want 0/0/0", bus.o_ex_opA, bus.o_ex_opB, bus.o_ex_rd); end
    tick();
    bus.i_wb_valid = 1'b1; bus.i_wb_rd = 5'd9;
    tick();
    bus.i_wb_valid = 1'b0;
  endtask

  task automatic test_reset_in_stall();
    bus.i_ex_ready = 1'b0;
    drive_dec(1'b1, 5'd1, 5'd2, 5'd12, 1'b1);
    tick();
    drive_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    vecs++; if (bus.dbg_state !== STALL || bus.dbg_pending !== 32'h0000_1000) begin errs++; $display("FAIL rst_pre got %0d/%h want 2/00001000", bus.dbg_state, bus.dbg_pending); end
    #2 i_reset = 1'b1;
    #1;
    vecs++; if (bus.o_ex_valid !== 1'b0 || bus.dbg_state !== IDLE) begin errs++; $display("FAIL rst_mid_valid got %0b/%0d want 0/IDLE", bus.o_ex_valid, bus.dbg_state); end
    vecs++; if (bus.dbg_pending !== 32'h0 || bus.o_ex_opA !== 32'h0 || bus.o_ex_rd !== 5'd0) begin errs++; $display("FAIL rst_mid_clear got %h/%h/%0d want 0/0/0", bus.dbg_pending, bus.o_ex_opA, bus.o_ex_rd); end
    tick();
    #2 i_reset = 1'b0;
    bus.i_ex_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_bypass();
    test_stall_back_to_back();
    test_flush();
    test_same_cycle_set_clear();
    test_reset_in_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter XLEN, default 32, operand/data width SHALL be XLEN bits.
REQ-002 Clock i_clk; reset i_reset, asynchronous, active-high.
REQ-003 i_clk  in  1  clock; all state changes on rising edge.
REQ-004 i_reset  in  1  asynchronous active-high reset.
REQ-005 i_dec_valid / o_dec_ready  in/out  1/1  decode handshake; transfer when both high at a rising edge.
REQ-006 i_dec_rs1, i_dec_rs2, i_dec_rd  in  5 each  source/destination register indices.
REQ-007 i_dec_wr  in  1  instruction writes rd.
REQ-008 o_rf_selA, o_rf_selB  out  5 each  register file read selects.
REQ-009 i_rf_portA, i_rf_portB  in  XLEN each  register file read data; registered, valid the cycle after the select.
REQ-010 i_wb_valid, i_wb_rd, i_wb_data  in  1/5/XLEN  writeback bus, same bus that writes the register file.
REQ-011 o_ex_valid / i_ex_ready  out/in  1/1  execute handshake.
REQ-012 o_ex_opA, o_ex_opB  out  XLEN each  resolved operands.
REQ-013 o_ex_rd, o_ex_wr  out  5/1  passed-through destination info.
REQ-014 i_flush  in  1  discard the instruction held in this block.

Function
REQ-015 FSM SHALL have states IDLE, ISSUED and STALL.
REQ-016 Operand stage: o_ex_valid SHALL be 0 in IDLE and 1 in ISSUED and STALL.
REQ-017 o_rf_selA/B SHALL equal i_dec_rs1/rs2 combinationally in every cycle.
REQ-018 Scoreboard: 31 pending bits (x1..x31); x0 SHALL never be pending.
REQ-019 Hazard SHALL be true if rs1, rs2, or rd (when i_dec_wr) is pending, unless i_wb_valid clears that same index this cycle.
REQ-020 o_dec_ready SHALL be !hazard && !i_flush && (state==IDLE || i_ex_ready).
REQ-021 Accept SHALL set pending[rd] when i_dec_wr && rd!=0, and SHALL go to ISSUED the next cycle.
REQ-022 i_wb_valid SHALL clear pending[i_wb_rd]; if the same index is set in the same cycle, set SHALL win.
REQ-023 Bypass: a writeback in the accept cycle with i_wb_rd==rs (rs!=0) SHALL latch i_wb_data; in ISSUED that value SHALL replace the stale i_rf_port data.
REQ-024 Operands for index 0 SHALL be 0 regardless of i_rf_port.
REQ-025 ISSUED with i_ex_ready: handshake completes; next state SHALL be ISSUED on a new accept, else IDLE.
REQ-026 ISSUED without i_ex_ready: operands SHALL be captured into hold registers; next state SHALL be STALL.
REQ-027 STALL SHALL present the hold registers; with i_ex_ready, next state SHALL be ISSUED on a new accept, else IDLE.
REQ-028 Latency SHALL be one cycle from accept to o_ex_valid; sustained throughput SHALL be one instruction per cycle with no hazards.
REQ-029 i_flush in ISSUED/STALL SHALL go to IDLE next cycle, with no handshake that cycle.
REQ-030 On flush, the held instruction's pending bit SHALL be cleared; other pending bits SHALL be kept.
REQ-031 Outputs SHALL hold stable while o_ex_valid && !i_ex_ready.

Reset
REQ-032 On i_reset, the FSM SHALL go to IDLE and all pending bits SHALL clear.
REQ-033 On i_reset, o_ex_valid, o_ex_opA/B, o_ex_rd, o_ex_wr and the bypass/hold registers SHALL go to 0.
REQ-034 Reset mid-operation SHALL drop any in-flight instruction without a handshake.

Structure
REQ-035 A shared package argon_pkg SHALL hold XLEN default, REG_ADDR_W=5 and the FSM state enum.
REQ-036 The scoreboard SHALL be a sub-module, operand_scoreboard: set port, clear port, three query ports, flush-clear port.

Verification
REQ-037 Reset, then accept rs1=3, rs2=0, rd=5, wr=1 with rf portA=0x11 -> o_ex_valid next cycle, opA=0x11, opB=0, pending[5]=1.
REQ-038 pending[5] set, dec rs1=5 -> o_dec_ready=0; wb rd=5 data=0xAB in the same cycle -> accepted, opA=0xAB via bypass.
REQ-039 i_ex_ready=0 for 3 cycles after issue -> STALL, operands unchanged, o_dec_ready=0; ready=1 with a new valid -> back-to-back issue.
REQ-040 Flush in STALL for an instruction with rd=7 -> IDLE, pending[7]=0, no EX handshake.
REQ-041 Same-cycle wb rd=9 and accept rd=9 wr=1 -> pending[9]=1 afterwards.
REQ-042 Assert i_reset during STALL -> o_ex_valid=0 immediately, scoreboard all zero.
